// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard, optional write bypass and
// a pending-producer counter. Decode reserves/reads, writeback writes.
module regfile_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          busy1,
    output logic          busy2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          rsv_en,
    input  logic [AW-1:0] rsv_a,
    input  logic          flush,
    output logic [AW:0]   pend_cnt,
    input  logic [AW-1:0] dbg_sel,
    output logic [DW-1:0] dbg_data,
    output logic          dbg_busy
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    rf_r [DEPTH];
    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_nxt_s;
    logic [AW:0]      pend_r;
    logic [AW:0]      pend_nxt_s;
    logic             wr_ok_s;
    logic             rsv_ok_s;
    logic             inc_s;
    logic             dec_s;

    function automatic logic is_prot(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == {AW{1'b0}});
    endfunction

    assign wr_ok_s  = we && !is_prot(wa);
    assign rsv_ok_s = rsv_en && !is_prot(rsv_a);

    // Next-state busy vector: flush or write-clear first, then reservation on top
    always_comb begin
        busy_nxt_s = busy_r;
        if (flush) begin
            busy_nxt_s = {DEPTH{1'b0}};
        end else if (wr_ok_s) begin
            busy_nxt_s[wa] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (rsv_ok_s) begin
            busy_nxt_s[rsv_a] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // Incremental pend counter; a write to the address being reserved never decrements
    always_comb begin
        inc_s      = rsv_ok_s && !busy_r[rsv_a];
        dec_s      = wr_ok_s && busy_r[wa] && !(rsv_ok_s && (rsv_a == wa));
        pend_nxt_s = pend_r;
        if (flush) begin
            pend_nxt_s = {{AW{1'b0}}, rsv_ok_s};
        end else begin
            pend_nxt_s = pend_r + {{AW{1'b0}}, inc_s} - {{AW{1'b0}}, dec_s};
        end
    end

    // State registers: data array, busy bits and pend counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_r[i] <= {DW{1'b0}};
            end
            busy_r <= {DEPTH{1'b0}};
            pend_r <= {(AW + 1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                rf_r[wa] <= wd;
            end
            busy_r <= busy_nxt_s;
            pend_r <= pend_nxt_s;
        end
    end

    // Read port 1: protected zero, then bypass, then stored value
    always_comb begin
        rd1   = rf_r[ra1];
        busy1 = busy_r[ra1];
        if (is_prot(ra1)) begin
            rd1   = {DW{1'b0}};
            busy1 = 1'b0;
        end else if ((BYPASS != 0) && we && (wa == ra1)) begin
            rd1   = rst ? rf_r[ra1] : wd;
            busy1 = 1'b0;
        end else begin
            rd1   = rf_r[ra1];
            busy1 = busy_r[ra1];
        end
    end

    // Read port 2: same structure as port 1
    always_comb begin
        rd2   = rf_r[ra2];
        busy2 = busy_r[ra2];
        if (is_prot(ra2)) begin
            rd2   = {DW{1'b0}};
            busy2 = 1'b0;
        end else if ((BYPASS != 0) && we && (wa == ra2)) begin
            rd2   = rst ? rf_r[ra2] : wd;
            busy2 = 1'b0;
        end else begin
            rd2   = rf_r[ra2];
            busy2 = busy_r[ra2];
        end
    end

    // Debug port never bypasses so the display shows committed state only
    always_comb begin
        dbg_busy = busy_r[dbg_sel];
        if (is_prot(dbg_sel)) begin
            dbg_data = {DW{1'b0}};
        end else begin
            dbg_data = rf_r[dbg_sel];
        end
    end

    assign pend_cnt = pend_r;

`ifndef SYNTHESIS
    // Trace each committed write
    always @(posedge clk) begin
        if (!rst && wr_ok_s) begin
            $display("regfile_sb: r%0d <= %h", wa, wd);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: default instance (zero reg, bypass) and an alternate
// instance (ordinary r0, no bypass) driven by the same stimulus.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic [AW-1:0] ra1, ra2, wa, rsv_a, dbg_sel;
    logic          we, rsv_en, flush;
    logic [DW-1:0] wd;

    logic [DW-1:0] d_rd1, d_rd2, d_dbg_data, a_rd1, a_rd2, a_dbg_data;
    logic          d_busy1, d_busy2, d_dbg_busy, a_busy1, a_busy2, a_dbg_busy;
    logic [AW:0]   d_pend, a_pend;

    int n_checks = 0;
    int n_errors = 0;

    regfile_sb #(.DW(DW), .AW(AW), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(d_rd1), .rd2(d_rd2),
        .busy1(d_busy1), .busy2(d_busy2), .we(we), .wa(wa), .wd(wd),
        .rsv_en(rsv_en), .rsv_a(rsv_a), .flush(flush), .pend_cnt(d_pend),
        .dbg_sel(dbg_sel), .dbg_data(d_dbg_data), .dbg_busy(d_dbg_busy)
    );

    regfile_sb #(.DW(DW), .AW(AW), .ZERO_REG(0), .BYPASS(0)) u_alt (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(a_rd1), .rd2(a_rd2),
        .busy1(a_busy1), .busy2(a_busy2), .we(we), .wa(wa), .wd(wd),
        .rsv_en(rsv_en), .rsv_a(rsv_a), .flush(flush), .pend_cnt(a_pend),
        .dbg_sel(dbg_sel), .dbg_data(a_dbg_data), .dbg_busy(a_dbg_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; rsv_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        wa = '0; wd = '0; rsv_a = '0; ra1 = '0; ra2 = '0; dbg_sel = '0;
        #12;
        // Reset state over every address
        for (int i = 0; i < 32; i++) begin
            ra1 = AW'(i); ra2 = AW'(31 - i); dbg_sel = AW'(i);
            #1;
            check_eq("rst_rd1", d_rd1, 0);
            check_eq("rst_rd2", d_rd2, 0);
            check_eq("rst_dbg", d_dbg_data, 0);
            check_eq("rst_busy1", d_busy1, 0);
            check_eq("rst_alt_rd1", a_rd1, 0);
        end
        check_eq("rst_pend", d_pend, 0);
        check_eq("rst_alt_pend", a_pend, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Same-cycle bypass vs stored path
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; ra1 = 5'd5;
        #1;
        check_eq("byp_rd1", d_rd1, 32'hDEAD_BEEF);
        check_eq("nobyp_rd1", a_rd1, 32'h0);
        tick();
        idle(); dbg_sel = 5'd5;
        #1;
        check_eq("wr_dbg", d_dbg_data, 32'hDEAD_BEEF);
        check_eq("wr_alt_dbg", a_dbg_data, 32'hDEAD_BEEF);
        check_eq("wr_alt_rd1", a_rd1, 32'hDEAD_BEEF);

        // Register 0: protected on default instance, ordinary on alternate
        we = 1'b1; wa = 5'd0; wd = 32'h1234; rsv_en = 1'b1; rsv_a = 5'd0; ra1 = 5'd0;
        #1;
        check_eq("r0_byp_rd1", d_rd1, 0);
        tick();
        idle();
        #1;
        check_eq("r0_rd1", d_rd1, 0);
        check_eq("r0_pend", d_pend, 0);
        check_eq("r0_busy1", d_busy1, 0);
        check_eq("r0_alt_rd1", a_rd1, 32'h1234);
        check_eq("r0_alt_pend", a_pend, 1);
        check_eq("r0_alt_busy1", a_busy1, 1);
        flush = 1'b1;
        tick();
        idle();
        check_eq("flush0_alt_pend", a_pend, 0);

        // Reserve r3, r7, r3 again
        rsv_en = 1'b1; rsv_a = 5'd3; tick();
        rsv_a = 5'd7; tick();
        rsv_a = 5'd3; tick();
        idle(); ra1 = 5'd3; ra2 = 5'd7; dbg_sel = 5'd3;
        #1;
        check_eq("rsv_pend", d_pend, 2);
        check_eq("rsv_alt_pend", a_pend, 2);
        check_eq("rsv_busy1", d_busy1, 1);
        check_eq("rsv_busy2", d_busy2, 1);
        we = 1'b1; wa = 5'd3; wd = 32'h33;
        #1;
        check_eq("byp_busy1", d_busy1, 0);
        check_eq("nobyp_busy1", a_busy1, 1);
        check_eq("dbg_busy_nobyp", d_dbg_busy, 1);
        tick();
        idle();
        check_eq("wclr_pend", d_pend, 1);
        check_eq("wclr_busy1", d_busy1, 0);
        check_eq("wclr_rd1", d_rd1, 32'h33);
        // Write and reserve the same busy register
        we = 1'b1; wa = 5'd7; wd = 32'h77; rsv_en = 1'b1; rsv_a = 5'd7;
        tick();
        idle(); ra1 = 5'd7;
        #1;
        check_eq("wr_rsv_rd1", d_rd1, 32'h77);
        check_eq("wr_rsv_busy1", d_busy1, 1);
        check_eq("wr_rsv_pend", d_pend, 1);
        check_eq("wr_rsv_alt_pend", a_pend, 1);

        // Flush with simultaneous reserve
        flush = 1'b1; tick(); idle();
        check_eq("flush_pend", d_pend, 0);
        we = 1'b1; wa = 5'd1; wd = 32'h11; tick();
        wa = 5'd2; wd = 32'h22; tick();
        wa = 5'd4; wd = 32'h44; tick();
        idle(); rsv_en = 1'b1;
        rsv_a = 5'd1; tick();
        rsv_a = 5'd2; tick();
        rsv_a = 5'd4; tick();
        check_eq("rsv3_pend", d_pend, 3);
        flush = 1'b1; rsv_a = 5'd9;
        tick();
        idle();
        check_eq("flrsv_pend", d_pend, 1);
        check_eq("flrsv_alt_pend", a_pend, 1);
        dbg_sel = 5'd9; #1;
        check_eq("flrsv_busy9", d_dbg_busy, 1);
        dbg_sel = 5'd1; #1;
        check_eq("flrsv_busy1", d_dbg_busy, 0);
        check_eq("flrsv_data1", d_dbg_data, 32'h11);
        dbg_sel = 5'd2; #1;
        check_eq("flrsv_data2", d_dbg_data, 32'h22);
        dbg_sel = 5'd4; #1;
        check_eq("flrsv_data4", d_dbg_data, 32'h44);
        // Write busy r9 while reserving idle r10: net zero
        we = 1'b1; wa = 5'd9; wd = 32'h99; rsv_en = 1'b1; rsv_a = 5'd10;
        tick();
        idle(); dbg_sel = 5'd10;
        #1;
        check_eq("xfer_pend", d_pend, 1);
        check_eq("xfer_busy10", d_dbg_busy, 1);

        // Asynchronous reset mid-cycle with activity pending
        we = 1'b1; wa = 5'd6; wd = 32'hAA; rsv_en = 1'b1; rsv_a = 5'd6; ra1 = 5'd6;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_pend", d_pend, 0);
        check_eq("arst_alt_pend", a_pend, 0);
        check_eq("arst_busy10", d_dbg_busy, 0);
        check_eq("arst_rd1", d_rd1, 0);
        dbg_sel = 5'd1; #1;
        check_eq("arst_data1", d_dbg_data, 0);
        @(posedge clk);
        #3;
        idle();
        rst = 1'b0;
        tick();
        we = 1'b1; wa = 5'd6; wd = 32'h55;
        tick();
        idle();
        check_eq("post_rst_rd1", d_rd1, 32'h55);
        check_eq("post_rst_alt_rd1", a_rd1, 32'h55);
        check_eq("post_rst_pend", d_pend, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
